hole_hit_scan: RTL

//  Consumer of the random hole-position list produced by the placement generator.
//  On each i_start, it scans every stored position against the ball centre.
//  It reports the lowest-index hole the ball has fallen into, and whether that hole is the goal.
//  It sits between the placement generator and the game-state controller, and runs once per frame tick.

---
 rtl/hole_hit_scan.sv | 95 +++++++++
 1 files changed

// File: rtl/hole_hit_scan.sv
// hole_hit_scan: scans the hole-position list for the lowest-index hole that captures the ball.
module hole_hit_scan #(
    parameter int MAX_NUM  = 9,
    parameter int RADIUS   = 16,
    parameter int GOAL_IDX = 1,
    parameter int SKIP_IDX = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [MAX_NUM*20-1:0] i_hole_list,
    input  logic                  i_list_valid,
    input  logic                  i_start,
    input  logic [9:0]            i_ball_x,
    input  logic [9:0]            i_ball_y,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_hit,
    output logic [3:0]            o_hit_idx,
    output logic                  o_goal
);
    typedef enum logic [1:0] {IDLE, DIFF, CMP, DONE} state_t;
    localparam logic [20:0] R2 = 21'(RADIUS * RADIUS);
    state_t state;
    logic [3:0] k;
    logic [9:0] bx, by, dx, dy, hx, hy;
    logic [20:0] sum;
    always_comb begin
        hx  = i_hole_list[10*k +: 10];
        hy  = i_hole_list[MAX_NUM*10 + 10*k +: 10];
        sum = 21'(dx) * 21'(dx) + 21'(dy) * 21'(dy);
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            k         <= '0;
            bx        <= '0;
            by        <= '0;
            dx        <= '0;
            dy        <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_hit     <= 1'b0;
            o_hit_idx <= '0;
            o_goal    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: if (i_start) begin
                    o_hit     <= 1'b0;
                    o_hit_idx <= '0;
                    o_goal    <= 1'b0;
                    if (i_list_valid) begin
                        bx     <= i_ball_x;
                        by     <= i_ball_y;
                        k      <= '0;
                        o_busy <= 1'b1;
                        state  <= DIFF;
                    end else begin
                        o_done <= 1'b1;
                        state  <= DONE;
                    end
                end
                DIFF: if (!i_list_valid) begin
                    o_busy <= 1'b0;
                    o_done <= 1'b1;
                    state  <= DONE;
                end else begin
                    dx    <= (bx > hx) ? bx - hx : hx - bx;
                    dy    <= (by > hy) ? by - hy : hy - by;
                    state <= CMP;
                end
                CMP: if (!i_list_valid) begin
                    o_busy <= 1'b0;
                    o_done <= 1'b1;
                    state  <= DONE;
                end else if (sum < R2 && k != 4'(SKIP_IDX)) begin
                    o_hit     <= 1'b1;
                    o_hit_idx <= k;
                    o_goal    <= (k == 4'(GOAL_IDX));
                    o_busy    <= 1'b0;
                    o_done    <= 1'b1;
                    state     <= DONE;
                end else if (k == 4'(MAX_NUM - 1)) begin
                    o_busy <= 1'b0;
                    o_done <= 1'b1;
                    state  <= DONE;
                end else begin
                    k     <= k + 4'd1;
                    state <= DIFF;
                end
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule
